keystat_ctrl: RTL and testbench

Owns the 51-entry key status array `keystat` that drives the keyboard display layer. Each entry is 8 bits: {BRGHT[2:0], COLOR[1:0], NSIZE[2:0]}. The block arbitrates three event requesters (note spawn, touch, judgement) onto a single read-modify-write update port. On every frame tick it runs a sequential sweep that grows entering notes and fades glows and exiting notes. It sits between the game logic / keyboard decoder and the display layer.

---
 rtl/keystat_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_keystat_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystat_ctrl.sv
// keystat_ctrl: owner of the per-key status array driving the keyboard display layer.
//
// Each entry is {BRGHT[2:0], COLOR[1:0], NSIZE[2:0]}. Three event requesters (spawn, touch,
// judge) share one read-modify-write update port under fixed priority judge > touch > spawn.
// Every frame tick launches a one-entry-per-cycle sweep that grows entering notes and
// fades glows and exiting notes.
//
// Ports:
//   Clk, Reset_n                   clock, asynchronous active-low reset
//   frame_tick                     one-cycle pulse per video frame
//   spawn_valid/key, spawn_ready   spawn request handshake
//   touch_valid/key, touch_ready   touch request handshake
//   judge_valid/key/res, judge_ready  judgement request handshake (res: 1 lost, 2 far, 3 pure)
//   keystat                        packed status array, entry k at [8*k +: 8]
//   busy                           sweep in progress
//   ovf_cnt                        dropped frame ticks, saturating
//
// Build option: define KEYSTAT_OVF_EN to implement ovf_cnt; otherwise it is tied to zero.

module keystat_ctrl #(
  parameter int unsigned NKEYS     = 51,
  parameter int unsigned DECAY_DIV = 2,
  parameter int unsigned GROW_DIV  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 spawn_valid,
  input  logic [5:0]           spawn_key,
  output logic                 spawn_ready,
  input  logic                 touch_valid,
  input  logic [5:0]           touch_key,
  output logic                 touch_ready,
  input  logic                 judge_valid,
  input  logic [5:0]           judge_key,
  input  logic [1:0]           judge_res,
  output logic                 judge_ready,
  output logic [8*NKEYS-1:0]   keystat,
  output logic                 busy,
  output logic [7:0]           ovf_cnt
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic [7:0] decay_ph_q, decay_ph_d;
  logic [7:0] grow_ph_q, grow_ph_d;
  logic       decay_step_q, decay_step_d;
  logic       grow_step_q, grow_step_d;
  logic [7:0] ks_q [NKEYS];

  logic       start_due;
  logic       wr_en;
  logic [5:0] wr_idx;
  logic [7:0] wr_data;
  logic [5:0] ev_key;
  logic       key_ok;
  logic [7:0] ev_cur;

  // Per-entry sweep update; arithmetic saturates, never wraps.
  function automatic logic [7:0] sweep_entry(logic [7:0] e, logic ds, logic gs);
    logic [2:0] b;
    logic [1:0] c;
    logic [2:0] n;
    b = e[7:5];
    c = e[4:3];
    n = e[2:0];
    if (c != 2'd0) begin
      if (ds) begin
        if (b > 3'd1) b = b - 3'd1;
        else begin
          b = 3'd0;
          c = 2'd0;
          n = 3'd0;
        end
      end
    end else if (n != 3'd0) begin
      if (gs && n != 3'd7) n = n + 3'd1;
    end else if (b != 3'd0) begin
      if (ds) b = b - 3'd1;
    end
    return {b, c, n};
  endfunction

  assign start_due = (state_q == StIdle) && (frame_tick || pending_q);
  assign busy      = (state_q == StSweep);

  // Event key of the highest-priority requester; out-of-range keys are accepted and dropped.
  assign ev_key = judge_valid ? judge_key : (touch_valid ? touch_key : spawn_key);
  assign key_ok = (32'(ev_key) < NKEYS);
  assign ev_cur = key_ok ? ks_q[ev_key] : 8'h00;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    decay_ph_d   = decay_ph_q;
    grow_ph_d    = grow_ph_q;
    decay_step_d = decay_step_q;
    grow_step_d  = grow_step_q;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_data      = 8'h00;
    spawn_ready  = 1'b0;
    touch_ready  = 1'b0;
    judge_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_due) begin
          state_d      = StSweep;
          idx_d        = '0;
          // A tick arriving while a pending start is consumed becomes the next pending one.
          pending_d    = pending_q && frame_tick;
          decay_step_d = (decay_ph_q == 8'd0);
          grow_step_d  = (grow_ph_q == 8'd0);
          decay_ph_d   = (decay_ph_q == 8'(DECAY_DIV - 1)) ? 8'd0 : decay_ph_q + 8'd1;
          grow_ph_d    = (grow_ph_q == 8'(GROW_DIV - 1)) ? 8'd0 : grow_ph_q + 8'd1;
        end else begin
          judge_ready = 1'b1;
          touch_ready = !judge_valid;
          spawn_ready = !judge_valid && !touch_valid;
          wr_idx      = ev_key;
          wr_data     = ev_cur;
          wr_en       = key_ok && (judge_valid || touch_valid || spawn_valid);
          if (judge_valid) begin
            if (ev_cur[2:0] != 3'd0 && judge_res != 2'd0) begin
              wr_data = {3'd7, judge_res, ev_cur[2:0]};
            end
          end else if (touch_valid) begin
            if (ev_cur[2:0] == 3'd0) wr_data = 8'hE0;
          end else begin
            wr_data = 8'hE1;
          end
        end
      end
      StSweep: begin
        if (frame_tick) pending_d = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = sweep_entry(ks_q[idx_q], decay_step_q, grow_step_q);
        if (idx_q == 6'(NKEYS - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      decay_ph_q   <= '0;
      grow_ph_q    <= '0;
      decay_step_q <= 1'b0;
      grow_step_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      decay_ph_q   <= decay_ph_d;
      grow_ph_q    <= grow_ph_d;
      decay_step_q <= decay_step_d;
      grow_step_q  <= grow_step_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NKEYS; i++) ks_q[i] <= 8'h00;
    end else if (wr_en) begin
      ks_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    keystat = '0;
    for (int i = 0; i < NKEYS; i++) keystat[8*i +: 8] = ks_q[i];
  end

`ifdef KEYSTAT_OVF_EN
  logic       tick_drop;
  logic [7:0] ovf_q;

  assign tick_drop = (state_q == StSweep) && frame_tick && pending_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 8'd0;
    end else if (tick_drop && ovf_q != 8'hFF) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_keystat_ctrl.sv
module tb_keystat_ctrl;

  localparam int NK = 51;
  localparam int DD = 2;
  localparam int GD = 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_tick = 1'b0;
  logic              spawn_valid = 1'b0;
  logic [5:0]        spawn_key = '0;
  logic              spawn_ready;
  logic              touch_valid = 1'b0;
  logic [5:0]        touch_key = '0;
  logic              touch_ready;
  logic              judge_valid = 1'b0;
  logic [5:0]        judge_key = '0;
  logic [1:0]        judge_res = '0;
  logic              judge_ready;
  logic [8*NK-1:0]   keystat;
  logic              busy;
  logic [7:0]        ovf_cnt;

  always #5 Clk = ~Clk;

  keystat_ctrl #(.NKEYS(NK), .DECAY_DIV(DD), .GROW_DIV(GD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_key(spawn_key), .spawn_ready(spawn_ready),
    .touch_valid(touch_valid), .touch_key(touch_key), .touch_ready(touch_ready),
    .judge_valid(judge_valid), .judge_key(judge_key), .judge_res(judge_res),
    .judge_ready(judge_ready), .keystat(keystat), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fields kept as plain integers, sweeps counted globally.
  int mb [NK];
  int mc [NK];
  int mn [NK];
  int sweeps;

  typedef struct {
    int         kind;   // 0 spawn, 1 touch, 2 judge
    int         key;
    int         res;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_entry(input int k);
    return mb[k] * 32 + mc[k] * 8 + mn[k];
  endfunction

  function automatic int d_entry(input int k);
    return int'(keystat[8*k +: 8]);
  endfunction

  task automatic check_all(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < NK; k++) if (bad < 0 && d_entry(k) != m_entry(k)) bad = k;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: key %0d got 0x%0h, expected 0x%0h", name, bad, d_entry(bad),
               m_entry(bad));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NK; k++) begin
      mb[k] = 0;
      mc[k] = 0;
      mn[k] = 0;
    end
    sweeps = 0;
  endtask

  task automatic model_event(input int kind, input int key, input int res);
    if (key >= NK) return;
    if (kind == 0) begin
      mb[key] = 7; mc[key] = 0; mn[key] = 1;
    end else if (kind == 1) begin
      if (mn[key] == 0) begin
        mb[key] = 7; mc[key] = 0;
      end
    end else begin
      if (mn[key] > 0 && res != 0) begin
        mb[key] = 7; mc[key] = res;
      end
    end
  endtask

  task automatic model_sweep();
    bit ds, gs;
    ds = (sweeps % DD) == 0;
    gs = (sweeps % GD) == 0;
    sweeps++;
    for (int k = 0; k < NK; k++) begin
      if (mc[k] != 0) begin
        if (ds) begin
          if (mb[k] > 1) mb[k]--;
          else begin mb[k] = 0; mc[k] = 0; mn[k] = 0; end
        end
      end else if (mn[k] > 0) begin
        if (gs && mn[k] < 7) mn[k]++;
      end else if (mb[k] > 0 && ds) begin
        mb[k]--;
      end
    end
  endtask

  function automatic logic rdy(input int kind);
    if (kind == 0) return spawn_ready;
    if (kind == 1) return touch_ready;
    return judge_ready;
  endfunction

  task automatic set_req(input int kind, input int key, input int res, input logic v);
    if (kind == 0) begin spawn_valid = v; spawn_key = 6'(key); end
    else if (kind == 1) begin touch_valid = v; touch_key = 6'(key); end
    else begin judge_valid = v; judge_key = 6'(key); judge_res = 2'(res); end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_event(input int kind, input int key, input int res);
    bit ok;
    ok = 0;
    set_req(kind, key, res, 1'b1);
    for (int t = 0; t < 200; t++) begin
      #1;
      if (rdy(kind)) begin ok = 1; break; end
      @(negedge Clk);
    end
    check("handshake", int'(ok), 1);
    if (ok) begin
      @(posedge Clk);
      @(negedge Clk);
      model_event(kind, key, res);
    end
    set_req(kind, key, res, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge after the sweep ends.
  task automatic do_frame();
    int cnt;
    frame_tick = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    frame_tick = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge Clk);
    end
    check("sweep_len", cnt, NK);
    model_sweep();
    check_all("sweep_array");
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_clear();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int exp_ovf;
    model_clear();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset asserted mid-sweep.
    do_event(0, 4, 0);
    do_event(1, 20, 0);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (20) @(negedge Clk);
    #3 Reset_n = 1'b0;
    model_clear();
    #1;
    check("rst_keystat", int'(keystat == '0), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf_cnt), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_ready", int'({judge_ready, touch_ready, spawn_ready}), 7);
    check("rst_busy2", int'(busy), 0);

    // Entering note growth and saturation.
    do_event(0, 3, 0);
    check("spawn3", d_entry(3), 'hE1);
    do_frame();
    check("grow_first", d_entry(3), 'hE2);
    for (int i = 1; i < 28; i++) do_frame();
    check("grow_sat", d_entry(3), 'hE7);

    // Judged note fades out.
    do_reset();
    do_event(0, 3, 0);
    do_event(2, 3, 3);
    check("judge_pure", d_entry(3), 'hF9);
    for (int i = 0; i < 12; i++) do_frame();
    check("fade_b1", d_entry(3), 'h39);
    do_frame();
    check("fade_gone", d_entry(3), 'h00);

    // Simultaneous requests, granted judge then touch then spawn.
    do_reset();
    set_req(2, 5, 2, 1'b1);
    set_req(1, 7, 0, 1'b1);
    set_req(0, 9, 0, 1'b1);
    #1;
    check("prio_rdy0", int'({judge_ready, touch_ready, spawn_ready}), 'b100);
    @(negedge Clk);
    set_req(2, 5, 2, 1'b0);
    model_event(2, 5, 2);
    #1;
    check("prio_rdy1", int'({judge_ready, touch_ready, spawn_ready}), 'b110);
    @(negedge Clk);
    set_req(1, 7, 0, 1'b0);
    model_event(1, 7, 0);
    #1;
    check("prio_rdy2", int'({judge_ready, touch_ready, spawn_ready}), 'b111);
    @(negedge Clk);
    set_req(0, 9, 0, 1'b0);
    model_event(0, 9, 0);
    check("prio_k5", d_entry(5), 'h00);
    check("prio_k7", d_entry(7), 'hE0);
    check("prio_k9", d_entry(9), 'hE1);
    check_all("prio_array");

    // Table of single events from a cleared array.
    tbl[0]  = '{0, 10, 0, 8'hE1};
    tbl[1]  = '{1, 10, 0, 8'hE1};
    tbl[2]  = '{2, 10, 2, 8'hF1};
    tbl[3]  = '{1, 11, 0, 8'hE0};
    tbl[4]  = '{2, 11, 3, 8'hE0};
    tbl[5]  = '{2, 10, 0, 8'hF1};
    tbl[6]  = '{2, 10, 3, 8'hF9};
    tbl[7]  = '{0, 10, 0, 8'hE1};
    tbl[8]  = '{1, 55, 0, 8'h00};
    tbl[9]  = '{2, 12, 1, 8'h00};
    tbl[10] = '{0, 12, 0, 8'hE1};
    tbl[11] = '{2, 12, 1, 8'hE9};
    tbl[12] = '{2, 63, 3, 8'h00};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      do_event(tbl[i].kind, tbl[i].key, tbl[i].res);
      if (tbl[i].key < NK) check($sformatf("tbl%0d", i), d_entry(tbl[i].key), int'(tbl[i].exp));
      check_all($sformatf("tbl%0d_array", i));
    end

    // Ticks during a sweep: one pends, two are dropped; back-to-back sweeps.
    do_reset();
    do_event(0, 1, 0);
    do_event(0, 2, 0);
    do_event(2, 2, 2);
    frame_tick = 1'b1;
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge Clk);
      frame_tick = (i == 5 || i == 10 || i == 15);
      #1;
      if (busy) cnt++;
      if (i == 51) begin
        check("gap_busy", int'(busy), 0);
        check("gap_ready", int'({judge_ready, touch_ready, spawn_ready}), 0);
      end
    end
    frame_tick = 1'b0;
    check("busy_cycles", cnt, 2 * NK);
`ifdef KEYSTAT_OVF_EN
    exp_ovf = 2;
`else
    exp_ovf = 0;
`endif
    check("ovf_cnt", int'(ovf_cnt), exp_ovf);
    model_sweep();
    model_sweep();
    check_all("double_sweep");
    @(negedge Clk);

    // Randomized events and frames against the model.
    for (int i = 0; i < 250; i++) begin
      int r, kind, key, res;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do_frame();
      end else begin
        kind = $urandom_range(0, 2);
        key  = ($urandom_range(0, 7) == 0) ? $urandom_range(51, 63) : $urandom_range(0, 50);
        res  = $urandom_range(0, 3);
        do_event(kind, key, res);
        check_all("rand_event");
      end
    end
    check("ovf_final", int'(ovf_cnt), exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
